// File: rtl/pixel_framebuffer.sv
// Double-buffered pixel store: the writer fills the back bank, the scanner reads the front bank.
// Banks swap only on frame_sync. Define FRAMEBUF_CLEAR_EN to build the back-bank bulk-clear engine.
module pixel_framebuffer #(
  parameter int N_COLS           = 8,
  parameter int PIXELS_PER_COL   = 8,
  parameter int BITS_PER_CHANNEL = 8,
  localparam int COL_W      = (N_COLS > 1) ? $clog2(N_COLS) : 1,
  localparam int ROW_W      = (PIXELS_PER_COL > 1) ? $clog2(PIXELS_PER_COL) : 1,
  localparam int PIXEL_W    = 3 * BITS_PER_CHANNEL,
  localparam int COL_BITS_W = PIXELS_PER_COL * PIXEL_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [COL_W+ROW_W-1:0] wr_addr,
  input  logic [PIXEL_W-1:0]     wr_data,
  output logic                   wr_ready,
  input  logic                   swap_req,
  input  logic                   frame_sync,
  output logic                   swap_pending,
  output logic                   swap_done,
  output logic                   front_sel,
  input  logic                   clear_req,
  output logic                   busy,
  input  logic [COL_W-1:0]       col_idx,
  output logic [COL_BITS_W-1:0]  col_bits
);

  typedef enum logic {IDLE, PENDING} swap_state_t;

  swap_state_t state, state_next;
  logic        swap_exec;
  logic        busy_q;

  logic [COL_BITS_W-1:0] mem [2][N_COLS];

  logic [COL_W-1:0] wr_x;
  logic [ROW_W-1:0] wr_y;
  logic             wr_hit;
  logic             back_sel;

  assign wr_x     = wr_addr[COL_W+ROW_W-1 -: COL_W];
  assign wr_y     = wr_addr[ROW_W-1:0];
  assign back_sel = ~front_sel;
  assign wr_ready = ~busy_q;
  assign busy     = busy_q;
  assign wr_hit   = wr_en && wr_ready && (int'(wr_x) < N_COLS) && (int'(wr_y) < PIXELS_PER_COL);

  assign swap_pending = (state == PENDING);

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_next = state;
    swap_exec  = frame_sync && (swap_pending || swap_req) && !busy_q;
    if (swap_exec)     state_next = IDLE;
    else if (swap_req) state_next = PENDING;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      front_sel <= 1'b0;
      swap_done <= 1'b0;
    end else begin
      state     <= state_next;
      front_sel <= front_sel ^ swap_exec;
      swap_done <= swap_exec;
    end
  end

`ifdef FRAMEBUF_CLEAR_EN
  logic [COL_W-1:0] clr_col;

  // Swaps and writes are blocked while busy, so the bank being cleared cannot change under us.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      clr_col <= '0;
    end else if (busy_q) begin
      if (int'(clr_col) == N_COLS - 1) busy_q <= 1'b0;
      clr_col <= clr_col + COL_W'(1);
    end else if (clear_req) begin
      busy_q  <= 1'b1;
      clr_col <= '0;
    end
  end
`else
  logic unused_clear_req;
  assign unused_clear_req = clear_req;
  assign busy_q           = 1'b0;
`endif

  // NOTE: storage sits in flops with async reset because both banks must read zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < N_COLS; c++)
          mem[b][c] <= '0;
    end else begin
      if (wr_hit) mem[back_sel][wr_x][int'(wr_y)*PIXEL_W +: PIXEL_W] <= wr_data;
`ifdef FRAMEBUF_CLEAR_EN
      if (busy_q) mem[back_sel][clr_col] <= '0;
`endif
    end
  end

  assign col_bits = (int'(col_idx) < N_COLS) ? mem[front_sel][col_idx] : '0;

endmodule
